// File: rtl/conv1_buf_arbiter.sv
// Shares one single-port BRAM between the conv1 result writer and the next-layer reader.
// Writes land at sequential addresses; a read is held off until its word has been written.
module conv1_buf_arbiter #(
    parameter int DEPTH  = 2562,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_grant_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] wr_count_o,
    output logic              buf_full_o,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    input  logic [DATA_W-1:0] bram_dout_i
);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t              state_q, state_d;
    logic                pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
    logic                rd_last_q, rd_last_d;
    logic                rd_valid_q, rd_valid_d;

    logic                wr_elig, rd_elig, wr_gnt, rd_gnt, wr_acc, full_next;
    logic [ADDR_W-1:0]   cnt_inc;

    always_comb begin
        wr_elig   = pend_vld_q && !start_i;
        // wr_count is DEPTH once full, so this compare also covers the FULL case
        rd_elig   = rd_req_i && !start_i && (rd_addr_i < wr_count_q);
        // rd_last_q clear means reads take the next tie
        wr_gnt    = wr_elig && (!rd_elig || rd_last_q);
        rd_gnt    = rd_elig && !wr_gnt;
        cnt_inc   = wr_count_q + {{(ADDR_W-1){1'b0}}, wr_gnt};
        full_next = (cnt_inc == DEPTH_A);

        wr_ready_o = (state_q == FILL) && !start_i && !full_next && (!pend_vld_q || wr_gnt);
        wr_acc     = wr_valid_i && wr_ready_o;

        bram_en_o   = wr_gnt || rd_gnt;
        bram_we_o   = wr_gnt;
        bram_addr_o = wr_gnt ? wr_count_q : (rd_gnt ? rd_addr_i : '0);
        bram_din_o  = wr_gnt ? pend_data_q : '0;

        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        wr_count_d  = wr_count_q;
        rd_last_d   = rd_last_q;
        rd_valid_d  = rd_valid_q;

        if (start_i) begin
            state_d    = FILL;
            pend_vld_d = 1'b0;
            wr_count_d = '0;
            rd_last_d  = 1'b0;
            rd_valid_d = 1'b0;
        end else begin
            rd_valid_d = rd_gnt;
            wr_count_d = cnt_inc;
            if (wr_acc) begin
                pend_vld_d  = 1'b1;
                pend_data_d = wr_data_i;
            end else if (wr_gnt) begin
                pend_vld_d  = 1'b0;
            end
            if (wr_gnt)
                rd_last_d = 1'b0;
            else if (rd_gnt)
                rd_last_d = 1'b1;
            if (state_q == FILL && full_next)
                state_d = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            wr_count_q  <= '0;
            rd_last_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            wr_count_q  <= wr_count_d;
            rd_last_q   <= rd_last_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_grant_o = rd_gnt;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = bram_dout_i;
    assign wr_count_o = wr_count_q;
    assign buf_full_o = (wr_count_q == DEPTH_A);

endmodule

// File: tb/tb_conv1_buf_arbiter.sv
// Bench for conv1_buf_arbiter: frame-level reference model checked every cycle, plus directed scenarios.
module tb_conv1_buf_arbiter;

    localparam int DEPTH = 2562;
    localparam int AW    = 12;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, wr_valid, rd_req;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          wr_ready, rd_grant, rd_valid, buf_full, bram_en, bram_we;
    logic [DW-1:0] rd_data, bram_din;
    logic [DW-1:0] bram_dout = '0;
    logic [AW-1:0] wr_count, bram_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    conv1_buf_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_grant_o(rd_grant),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_count_o(wr_count), .buf_full_o(buf_full),
        .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
        .bram_din_o(bram_din), .bram_dout_i(bram_dout)
    );

    always #5 clk = ~clk;

    // single-port BRAM, one-cycle read latency
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (bram_en && bram_we)  mem[bram_addr] <= bram_din;
        if (bram_en && !bram_we) bram_dout <= mem[bram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // index of the next word the frame will accept
    always @(negedge clk) begin
        if (!rst_n || start) hs_cnt <= 0;
        else if (wr_valid && wr_ready) hs_cnt <= hs_cnt + 1;
    end

    // Reference: frame = ordered list of accepted words; words [0, m_cnt) are in the
    // BRAM, words [m_cnt, m_acc) are waiting (at most one).
    logic [DW-1:0] gold [0:4095];
    bit m_started = 0, m_wturn = 0, m_rdv = 0;
    int m_cnt = 0, m_acc = 0, m_rdv_addr = 0;

    always @(negedge clk) begin
        bit wg, rg, re, we, exp_rdy;
        if (!rst_n) begin
            chk("rst_wr_ready", 32'(wr_ready), 0);
            chk("rst_rd_grant", 32'(rd_grant), 0);
            chk("rst_rd_valid", 32'(rd_valid), 0);
            chk("rst_wr_count", 32'(wr_count), 0);
            chk("rst_buf_full", 32'(buf_full), 0);
            chk("rst_bram_en", 32'(bram_en), 0);
            chk("rst_bram_we", 32'(bram_we), 0);
            chk("rst_bram_addr", 32'(bram_addr), 0);
            chk("rst_bram_din", bram_din, 0);
            m_started = 0; m_cnt = 0; m_acc = 0; m_wturn = 0; m_rdv = 0;
        end else begin
            wg = 0; rg = 0;
            if (!start) begin
                re = rd_req && (int'(rd_addr) < m_cnt);
                we = (m_acc > m_cnt);
                if (re && we) begin
                    wg = m_wturn; rg = !m_wturn;
                end else begin
                    wg = we; rg = re;
                end
            end
            exp_rdy = !start && m_started && (m_acc < DEPTH) && (m_acc - m_cnt - int'(wg) == 0);
            chk("m_wr_ready", 32'(wr_ready), 32'(exp_rdy));
            chk("m_rd_grant", 32'(rd_grant), 32'(rg));
            chk("m_wr_count", 32'(wr_count), m_cnt);
            chk("m_buf_full", 32'(buf_full), 32'(m_cnt == DEPTH));
            chk("m_rd_valid", 32'(rd_valid), 32'(m_rdv));
            if (m_rdv) chk("m_rd_data", rd_data, gold[m_rdv_addr]);
            chk("m_bram_en", 32'(bram_en), 32'(wg || rg));
            chk("m_bram_we", 32'(bram_we), 32'(wg));
            if (wg) begin
                chk("m_wr_addr", 32'(bram_addr), m_cnt);
                chk("m_wr_din", bram_din, gold[m_cnt]);
            end
            if (rg) chk("m_rd_addr", 32'(bram_addr), 32'(rd_addr));
            if (start) begin
                m_started = 1; m_cnt = 0; m_acc = 0; m_wturn = 0; m_rdv = 0;
            end else begin
                if (wr_valid && exp_rdy) begin
                    gold[m_acc] = wr_data;
                    m_acc++;
                end
                if (wg) begin m_cnt++; m_wturn = 0; end
                if (rg) m_wturn = 1;
                m_rdv = rg;
                m_rdv_addr = int'(rd_addr);
            end
        end
    end

    task automatic cyc();  @(posedge clk); #1; endtask
    task automatic look(); @(negedge clk); #1; endtask

    initial begin
        bit adv_w, adv_r, got_full;
        int nxt;
        rst_n = 0; start = 0; wr_valid = 0; wr_data = '0; rd_req = 0; rd_addr = '0;
        repeat (2) begin look(); chk("reset_wr_count", 32'(wr_count), 0); end
        cyc();

        // out of reset but no start: nothing is accepted or granted
        rst_n = 1; wr_valid = 1; wr_data = 32'hDEADBEEF; rd_req = 1; rd_addr = '0;
        repeat (4) begin
            look();
            chk("idle_wr_ready", 32'(wr_ready), 0);
            chk("idle_rd_grant", 32'(rd_grant), 0);
            cyc();
        end
        wr_valid = 0; rd_req = 0; start = 1;
        look(); cyc();
        start = 0;

        // basic fill and read-back
        wr_valid = 1; wr_data = 32'h04030201;
        look(); chk("basic_ready0", 32'(wr_ready), 1); cyc();
        wr_data = 32'h08070605;
        look();
        chk("basic_we0", 32'(bram_we), 1);
        chk("basic_addr0", 32'(bram_addr), 0);
        chk("basic_din0", bram_din, 32'h04030201);
        chk("basic_ready1", 32'(wr_ready), 1);
        cyc();
        wr_valid = 0;
        look();
        chk("basic_we1", 32'(bram_we), 1);
        chk("basic_addr1", 32'(bram_addr), 1);
        chk("basic_din1", bram_din, 32'h08070605);
        cyc();
        rd_req = 1; rd_addr = 12'd1;
        look(); chk("basic_count", 32'(wr_count), 2); chk("basic_grant", 32'(rd_grant), 1); cyc();
        rd_req = 0;
        look(); chk("basic_rvalid", 32'(rd_valid), 1); chk("basic_rdata", rd_data, 32'h08070605); cyc();

        // read-ahead stall on address 5
        wr_valid = 1; wr_data = 32'h0C0B0A09;
        look(); cyc();
        wr_valid = 0;
        look(); cyc();
        rd_req = 1; rd_addr = 12'd5;
        repeat (3) begin
            look();
            chk("stall_count", 32'(wr_count), 3);
            chk("stall_grant", 32'(rd_grant), 0);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            wr_valid = (k < 3);
            wr_data  = 32'h13131313 + 32'(k) * 32'h01010101;
            look(); chk("stall_grant_w", 32'(rd_grant), 0); cyc();
        end
        wr_valid = 0;
        look(); chk("stall_release", 32'(rd_grant), 1); chk("stall_count6", 32'(wr_count), 6); cyc();
        rd_req = 0;
        look(); chk("stall_rdata", rd_data, 32'h15151515); cyc();

        // contention: R,W,R,W starting with R once the read becomes eligible
        wr_valid = 1; wr_data = 32'h20000006; nxt = 7; rd_req = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin rd_req = 1; rd_addr = '0; end
            look();
            if (k >= 2) begin
                chk("cont_rd_grant", 32'(rd_grant), 32'((k - 2) % 2 == 0));
                chk("cont_wr_grant", 32'(bram_we), 32'((k - 2) % 2 == 1));
                chk("cont_count", 32'(wr_count), 32'(7 + (k - 2) / 2));
            end
            adv_w = wr_valid && wr_ready;
            adv_r = rd_grant;
            cyc();
            if (adv_w) begin wr_data = 32'h20000000 | 32'(nxt); nxt++; end
            if (adv_r) rd_addr = rd_addr + 12'd1;
        end
        rd_req = 0; wr_valid = 0;
        look(); chk("cont_final_count", 32'(wr_count), 11); cyc();

        // fill to the end of the frame
        wr_valid = 1; got_full = 0;
        for (int i = 0; i < 3000 && !got_full; i++) begin
            wr_data = 32'h5A000000 | 32'(hs_cnt);
            look();
            if (buf_full) got_full = 1;
            else cyc();
        end
        chk("full_reached", 32'(got_full), 1);
        chk("full_count", 32'(wr_count), DEPTH);
        chk("full_ready", 32'(wr_ready), 0);
        cyc();
        repeat (2) begin
            look();
            chk("full_ignore_en", 32'(bram_en), 0);
            chk("full_ignore_ready", 32'(wr_ready), 0);
            cyc();
        end
        wr_valid = 0; rd_req = 1; rd_addr = 12'd2561;
        look(); chk("full_last_grant", 32'(rd_grant), 1); cyc();
        rd_req = 0;
        look(); chk("full_last_valid", 32'(rd_valid), 1); chk("full_last_data", rd_data, 32'h5A000A01); cyc();
        rd_req = 1; rd_addr = 12'd2562;
        repeat (3) begin look(); chk("oob_grant", 32'(rd_grant), 0); cyc(); end
        rd_addr = 12'd4095;
        look(); chk("oob_grant_max", 32'(rd_grant), 0); cyc();

        // restart mid-frame with a pending write and a concurrent wr_valid
        rd_req = 0; start = 1;
        look(); cyc();
        start = 0; wr_valid = 1;
        for (int k = 0; k < 3; k++) begin
            wr_data = 32'h60000000 | 32'(k);
            look(); chk("restart_fill_ready", 32'(wr_ready), 1); cyc();
        end
        start = 1; wr_data = 32'h66666666;
        look();
        chk("start_no_access", 32'(bram_en), 0);
        chk("start_no_ready", 32'(wr_ready), 0);
        chk("start_prev_count", 32'(wr_count), 2);
        cyc();
        start = 0; wr_data = 32'h77777777;
        look();
        chk("start_count0", 32'(wr_count), 0);
        chk("start_full0", 32'(buf_full), 0);
        chk("start_ready", 32'(wr_ready), 1);
        cyc();
        wr_valid = 0;
        look();
        chk("start_we", 32'(bram_we), 1);
        chk("start_addr", 32'(bram_addr), 0);
        chk("start_din", bram_din, 32'h77777777);
        cyc();

        // reset in the middle of traffic
        wr_valid = 1; wr_data = 32'h88888888; rd_req = 1; rd_addr = '0;
        look(); cyc();
        look(); cyc();
        rst_n = 0;
        look();
        chk("midrst_ready", 32'(wr_ready), 0);
        chk("midrst_grant", 32'(rd_grant), 0);
        chk("midrst_rvalid", 32'(rd_valid), 0);
        chk("midrst_count", 32'(wr_count), 0);
        chk("midrst_full", 32'(buf_full), 0);
        chk("midrst_en", 32'(bram_en), 0);
        chk("midrst_we", 32'(bram_we), 0);
        chk("midrst_addr", 32'(bram_addr), 0);
        chk("midrst_din", bram_din, 0);
        cyc();
        rst_n = 1;
        repeat (3) begin
            look();
            chk("postrst_ready", 32'(wr_ready), 0);
            chk("postrst_grant", 32'(rd_grant), 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
